// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: op codes and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_SHL   = 3'd3,
    OP_SHR   = 3'd4,
    OP_ROTL  = 3'd5,
    OP_ROTR  = 3'd6,
    OP_ASHR  = 3'd7
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Shift/rotate ops run as multi-cycle bursts; the rest complete in one edge.
  function automatic logic is_shift_op(input op_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) ||
           (op == OP_ROTR) || (op == OP_ASHR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// One combinational shift/rotate step of the register, plus the bit pushed out.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] q,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  // Compute next contents and the outgoing bit for a single step.
  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROTL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROTR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASHR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/clear in one edge, shift/rotate bursts
// of shamt steps under a valid/busy/done handshake.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               SHAMT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   d,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   q,
  output logic               shift_out,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               so_q, so_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  op_t                op_in;
  op_t                step_op;
  logic [WIDTH-1:0]   step_q;
  logic               step_out;

  assign op_in   = op_t'(op);
  // In IDLE the stepper sees the incoming op; during a burst, the latched one.
  assign step_op = (state_q == IDLE) ? op_in : op_q;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op        (step_op),
    .q         (q_q),
    .serial_in (serial_in),
    .q_next    (step_q),
    .out_bit   (step_out)
  );

  // Next-state logic: accept requests in IDLE, advance one step per edge in SHIFT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (is_shift_op(op_in)) begin
            if (shamt != '0) begin
              op_d    = op_in;
              cnt_d   = shamt;
              state_d = SHIFT;
              busy_d  = 1'b1;
            end else begin
              // Zero-step shift completes immediately with q untouched.
              done_d = 1'b1;
            end
          end else begin
            if (op_in == OP_LOAD) begin
              q_d = d;
            end else if (op_in == OP_CLEAR) begin
              q_d = '0;
            end
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        q_d   = step_q;
        so_d  = step_out;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign shift_out = so_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
